// File: rtl/ps2_keyboard_decoder_pkg.sv
// Shared constants for the PS/2 keyboard decoder: the receive FSM state
// encoding, PS/2 prefix bytes and the Hack key codes for non-printing keys.
package ps2_keyboard_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [7:0] HACK_KEY_ENTER     = 8'd128;
  localparam logic [7:0] HACK_KEY_BACKSPACE = 8'd129;
  localparam logic [7:0] HACK_KEY_LEFT      = 8'd130;
  localparam logic [7:0] HACK_KEY_UP        = 8'd131;
  localparam logic [7:0] HACK_KEY_RIGHT     = 8'd132;
  localparam logic [7:0] HACK_KEY_DOWN      = 8'd133;
  localparam logic [7:0] HACK_KEY_HOME      = 8'd134;
  localparam logic [7:0] HACK_KEY_END       = 8'd135;
  localparam logic [7:0] HACK_KEY_PGUP      = 8'd136;
  localparam logic [7:0] HACK_KEY_PGDN      = 8'd137;
  localparam logic [7:0] HACK_KEY_INS       = 8'd138;
  localparam logic [7:0] HACK_KEY_DEL       = 8'd139;
  localparam logic [7:0] HACK_KEY_ESC       = 8'd140;
  localparam logic [7:0] HACK_KEY_F1        = 8'd141;

endpackage

// File: rtl/ps2_keyboard_decoder_if.sv
// PS/2 line inputs and decoded key outputs. The slave modport is the
// decoder; the master modport is whatever drives the PS/2 lines and reads
// the key state. rx_state exposes the receive FSM for observation.
// Handshake: scancode_valid is a single-cycle strobe with no back-pressure;
// scancode and key_code are valid in the strobe cycle and held afterwards.
interface ps2_keyboard_decoder_if
  import ps2_keyboard_decoder_pkg::*;
#(
  parameter int WORD_WIDTH = 16
);
  logic                  ps2_clk;
  logic                  ps2_data;
  logic [WORD_WIDTH-1:0] key_code;
  logic                  key_pressed;
  logic [7:0]            scancode;
  logic                  scancode_valid;
  logic                  frame_error;
  rx_state_e             rx_state;

  modport slave (
    input  ps2_clk, ps2_data,
    output key_code, key_pressed, scancode, scancode_valid, frame_error, rx_state
  );

  modport master (
    output ps2_clk, ps2_data,
    input  key_code, key_pressed, scancode, scancode_valid, frame_error, rx_state
  );
endinterface

// File: rtl/ps2_scancode_to_hack.sv
// Combinational map from a set-2 make code to an 8-bit Hack key code.
// The extended (E0-prefixed) table is only built when EXTENDED_KEYS_EN is defined.
module ps2_scancode_to_hack
  import ps2_keyboard_decoder_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_i,
  output logic [7:0] hack_o
);

`ifndef EXTENDED_KEYS_EN
  logic unused_ext;
  assign unused_ext = ext_i;
`endif

  // Table lookup; unmapped codes give 0
  always_comb begin
    hack_o = 8'd0;
`ifdef EXTENDED_KEYS_EN
    if (ext_i) begin
      case (code_i)
        8'h6B: hack_o = HACK_KEY_LEFT;
        8'h75: hack_o = HACK_KEY_UP;
        8'h74: hack_o = HACK_KEY_RIGHT;
        8'h72: hack_o = HACK_KEY_DOWN;
        8'h6C: hack_o = HACK_KEY_HOME;
        8'h69: hack_o = HACK_KEY_END;
        8'h7D: hack_o = HACK_KEY_PGUP;
        8'h7A: hack_o = HACK_KEY_PGDN;
        8'h70: hack_o = HACK_KEY_INS;
        8'h71: hack_o = HACK_KEY_DEL;
        default: hack_o = 8'd0;
      endcase
    end else
`endif
    begin
      case (code_i)
        8'h1C: hack_o = 8'd65;  8'h32: hack_o = 8'd66;  8'h21: hack_o = 8'd67;
        8'h23: hack_o = 8'd68;  8'h24: hack_o = 8'd69;  8'h2B: hack_o = 8'd70;
        8'h34: hack_o = 8'd71;  8'h33: hack_o = 8'd72;  8'h43: hack_o = 8'd73;
        8'h3B: hack_o = 8'd74;  8'h42: hack_o = 8'd75;  8'h4B: hack_o = 8'd76;
        8'h3A: hack_o = 8'd77;  8'h31: hack_o = 8'd78;  8'h44: hack_o = 8'd79;
        8'h4D: hack_o = 8'd80;  8'h15: hack_o = 8'd81;  8'h2D: hack_o = 8'd82;
        8'h1B: hack_o = 8'd83;  8'h2C: hack_o = 8'd84;  8'h3C: hack_o = 8'd85;
        8'h2A: hack_o = 8'd86;  8'h1D: hack_o = 8'd87;  8'h22: hack_o = 8'd88;
        8'h35: hack_o = 8'd89;  8'h1A: hack_o = 8'd90;
        8'h45: hack_o = 8'd48;  8'h16: hack_o = 8'd49;  8'h1E: hack_o = 8'd50;
        8'h26: hack_o = 8'd51;  8'h25: hack_o = 8'd52;  8'h2E: hack_o = 8'd53;
        8'h36: hack_o = 8'd54;  8'h3D: hack_o = 8'd55;  8'h3E: hack_o = 8'd56;
        8'h46: hack_o = 8'd57;
        8'h29: hack_o = 8'd32;
        8'h5A: hack_o = HACK_KEY_ENTER;
        8'h66: hack_o = HACK_KEY_BACKSPACE;
        8'h76: hack_o = HACK_KEY_ESC;
        8'h05: hack_o = HACK_KEY_F1;        8'h06: hack_o = HACK_KEY_F1 + 8'd1;
        8'h04: hack_o = HACK_KEY_F1 + 8'd2; 8'h0C: hack_o = HACK_KEY_F1 + 8'd3;
        8'h03: hack_o = HACK_KEY_F1 + 8'd4; 8'h0B: hack_o = HACK_KEY_F1 + 8'd5;
        8'h83: hack_o = HACK_KEY_F1 + 8'd6; 8'h0A: hack_o = HACK_KEY_F1 + 8'd7;
        8'h01: hack_o = HACK_KEY_F1 + 8'd8; 8'h09: hack_o = HACK_KEY_F1 + 8'd9;
        8'h78: hack_o = HACK_KEY_F1 + 8'd10; 8'h07: hack_o = HACK_KEY_F1 + 8'd11;
        default: hack_o = 8'd0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver and Hack key-code register, clocked by the SoC clk.
// Synchronises and deglitches the PS/2 lines, frames bytes (start, 8 data
// LSB first, odd parity, stop), aborts stalled frames after TIMEOUT_CLKS,
// and tracks the currently held key. Optional macro: EXTENDED_KEYS_EN
// enables the E0-prefixed navigation-key table.
module ps2_keyboard_decoder
  import ps2_keyboard_decoder_pkg::*;
#(
  parameter int WORD_WIDTH   = 16,
  parameter int FILTER_LEN   = 4,
  parameter int TIMEOUT_CLKS = 50000
)(
  input  logic                   clk,
  input  logic                   reset,
  ps2_keyboard_decoder_if.slave  bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  logic [1:0]            clk_sync_q, data_sync_q;
  logic                  clk_filt_q;
  logic [FW-1:0]         filt_cnt_q;
  rx_state_e             state_q;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic                  parity_q;
  logic [TW-1:0]         tmo_q;
  logic [7:0]            scancode_q;
  logic                  sc_valid_q, frame_err_q;
  logic [WORD_WIDTH-1:0] key_q, key_d;
  logic                  key_pressed_q;
  logic                  brk_q, brk_d;
  logic                  fall_w, data_w, accept_w, map_ext_w;
  logic [7:0]            map_w;
  logic [WORD_WIDTH-1:0] map_wide_w;

`ifdef EXTENDED_KEYS_EN
  logic ext_q, ext_d;
  assign map_ext_w = ext_q;
`else
  assign map_ext_w = 1'b0;
`endif

  // Both lines idle high, so the synchronisers and filter reset to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk};
      data_sync_q <= {data_sync_q[0], bus.ps2_data};
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_LAST) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  // A falling edge is accepted in the cycle the filtered level flips low
  assign fall_w   = clk_filt_q && !clk_sync_q[1] && (filt_cnt_q == FILT_LAST);
  assign data_w   = data_sync_q[1];
  assign accept_w = fall_w && (state_q == ST_STOP) && data_w && (^{shift_q, parity_q});

  // Receive FSM with timeout; strobes are registered so they follow the edge by one clk
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      scancode_q  <= '0;
      sc_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sc_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (fall_w || state_q == ST_IDLE) tmo_q <= '0;
      else                              tmo_q <= tmo_q + TW'(1);

      if (state_q != ST_IDLE && !fall_w && tmo_q == TMO_LAST) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
      end else if (fall_w) begin
        case (state_q)
          ST_IDLE: begin
            if (!data_w) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_q   <= {data_w, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_q <= data_w;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            if (accept_w) begin
              scancode_q <= shift_q;
              sc_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_scancode_to_hack u_map (
    .code_i (shift_q),
    .ext_i  (map_ext_w),
    .hack_o (map_w)
  );

  assign map_wide_w = {{(WORD_WIDTH-8){1'b0}}, map_w};

  // Key tracking: prefixes set flags, other bytes make/break the held key
  always_comb begin
    key_d = key_q;
    brk_d = brk_q;
`ifdef EXTENDED_KEYS_EN
    ext_d = ext_q;
`endif
    if (accept_w) begin
      if (shift_q == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (shift_q == PS2_EXT) begin
`ifdef EXTENDED_KEYS_EN
        ext_d = 1'b1;
`endif
      end else begin
        if (brk_q) begin
          if (map_wide_w == key_q) key_d = '0;
        end else if (map_w != 8'd0) begin
          key_d = map_wide_w;
        end
        brk_d = 1'b0;
`ifdef EXTENDED_KEYS_EN
        ext_d = 1'b0;
`endif
      end
    end
  end

  // Key registers update on the same edge that raises scancode_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q         <= '0;
      key_pressed_q <= 1'b0;
      brk_q         <= 1'b0;
`ifdef EXTENDED_KEYS_EN
      ext_q         <= 1'b0;
`endif
    end else begin
      key_q         <= key_d;
      key_pressed_q <= (key_d != '0);
      brk_q         <= brk_d;
`ifdef EXTENDED_KEYS_EN
      ext_q         <= ext_d;
`endif
    end
  end

  assign bus.key_code       = key_q;
  assign bus.key_pressed    = key_pressed_q;
  assign bus.scancode       = scancode_q;
  assign bus.scancode_valid = sc_valid_q;
  assign bus.frame_error    = frame_err_q;
  assign bus.rx_state       = state_q;

endmodule
